// File: rtl/mmio_pkg.sv
// Shared MMIO decode codes, UART transmitter state encoding and status-word layout.
package mmio_pkg;

  localparam logic [1:0]  PSEL_NONE      = 2'b00;
  localparam logic [1:0]  PSEL_RAM       = 2'b01;
  localparam logic [1:0]  PSEL_UART      = 2'b10;
  localparam logic [1:0]  PSEL_ETH       = 2'b11;
  localparam logic [31:0] MMIO_UART_ADDR = 32'hffff0000;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int ST_CNT_LSB = 0;
  localparam int ST_EMPTY   = 4;
  localparam int ST_FULL    = 5;
  localparam int ST_BUSY    = 6;
  localparam int ST_OVF     = 7;

  function automatic logic [31:0] pack_status(input logic ovf, input logic busy,
                                              input logic full, input logic empty,
                                              input logic [3:0] cnt);
    logic [31:0] s;
    s = '0;
    s[ST_OVF]                   = ovf;
    s[ST_BUSY]                  = busy;
    s[ST_FULL]                  = full;
    s[ST_EMPTY]                 = empty;
    s[ST_CNT_LSB+3:ST_CNT_LSB]  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Power-of-two FIFO for outgoing UART bytes; a push into a full FIFO is accepted
// only when a pop frees an entry on the same edge.
module uart_tx_fifo
  import mmio_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: decoder-select store/load interface, TX FIFO and an 8N1
// LSB-first serialiser whose next frame starts straight out of the stop bit.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  pselect,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic           sel, push, rd, pop;
  logic           full, empty, busy, overflow;
  logic [7:0]     dout;
  logic [CW-1:0]  count;
  logic           unused_wdata;

  uart_tx_state_t state, state_n;
  logic [BW-1:0]  baud_cnt, baud_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shreg, shreg_n;
  logic           tx_n;
  logic           baud_end;

  assign sel          = (pselect == PSEL_UART);
  assign push         = sel & we;
  assign rd           = sel & re & ~we;
  assign busy         = (state != IDLE);
  assign irq_empty    = empty & ~busy;
  assign unused_wdata = ^writedata[31:8];
  assign readdata     = (sel & re) ? pack_status(overflow, busy, full, empty, 4'(count))
                                   : 32'h0;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (writedata[7:0]),
    .dout    (dout),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // a drop sets overflow; the set beats a same-edge clear by a status read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                overflow <= 1'b0;
    else if (push & full & ~pop) overflow <= 1'b1;
    else if (rd)                 overflow <= 1'b0;
  end

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = dout;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n  = '0;
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 1'b1;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = dout;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // tx is registered from the next state so the line level lines up with the state register
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      tx       <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with 4 clocks per bit and a 4-entry FIFO.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  pselect;
  logic        we;
  logic        re;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx;
  logic        irq_empty;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mmio_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pselect   (pselect),
    .we        (we),
    .re        (re),
    .writedata (writedata),
    .readdata  (readdata),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame patterns: bit0 = start, bits 8:1 = data LSB first, bit9 = stop.
  localparam logic [9:0] F55 = 10'b1_01010101_0;
  localparam logic [9:0] FA3 = 10'b1_10100011_0;
  localparam logic [9:0] F0F = 10'b1_00001111_0;
  localparam logic [9:0] F81 = 10'b1_10000001_0;
  localparam logic [9:0] F3C = 10'b1_00111100_0;
  localparam logic [9:0] FE7 = 10'b1_11100111_0;
  localparam logic [9:0] F02 = 10'b1_00000010_0;
  localparam logic [9:0] FC5 = 10'b1_11000101_0;

  function automatic logic [39:0] expand(input logic [9:0] f);
    logic [39:0] r;
    for (int i = 0; i < 40; i++) r[i] = f[i/4];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] ps, input logic [7:0] b);
    pselect   = ps;
    we        = 1'b1;
    writedata = {24'h0, b};
    tick();
    we        = 1'b0;
    pselect   = 2'b00;
  endtask

  task automatic read_status(input logic [1:0] ps, output logic [31:0] v);
    pselect = ps;
    re      = 1'b1;
    #1;
    v       = readdata;
    re      = 1'b0;
    pselect = 2'b00;
  endtask

  task automatic capture(input int n, output logic [199:0] obs);
    obs = '0;
    for (int i = 0; i < n; i++) begin
      obs[i] = tx;
      tick();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!irq_empty && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (!irq_empty) begin
      failures++;
      $display("FAIL wait_idle timeout irq_empty=%b required=1", irq_empty);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL reset_tx got=%b exp=1", tx);
    end
    read_status(2'b10, v);
    checks++;
    if (v !== 32'h0000_0010) begin
      failures++; $display("FAIL reset_status got=%h exp=00000010", v);
    end
    checks++;
    if (irq_empty !== 1'b1) begin
      failures++; $display("FAIL reset_irq got=%b exp=1", irq_empty);
    end
  endtask

  task automatic test_single();
    logic [199:0] obs;
    store(2'b10, 8'h55);
    checks++;
    if (tx !== 1'b1 || irq_empty !== 1'b0) begin
      failures++; $display("FAIL single_pre tx=%b irq=%b exp tx=1 irq=0", tx, irq_empty);
    end
    tick();
    capture(40, obs);
    checks++;
    if (obs[39:0] !== expand(F55)) begin
      failures++; $display("FAIL single_frame got=%h exp=%h", obs[39:0], expand(F55));
    end
    checks++;
    if (irq_empty !== 1'b1 || tx !== 1'b1) begin
      failures++; $display("FAIL single_done irq=%b tx=%b exp irq=1 tx=1", irq_empty, tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [199:0] obs;
    logic [79:0]  exp;
    store(2'b10, 8'hA3);
    store(2'b10, 8'h0F);
    capture(80, obs);
    exp = {expand(F0F), expand(FA3)};
    checks++;
    if (obs[79:0] !== exp) begin
      failures++; $display("FAIL b2b_frames got=%h exp=%h", obs[79:0], exp);
    end
    checks++;
    if (irq_empty !== 1'b1) begin
      failures++; $display("FAIL b2b_done irq=%b exp=1", irq_empty);
    end
  endtask

  task automatic test_wrong_select();
    logic [1:0]  ps [3];
    logic [31:0] v;
    logic        saw_low;
    ps[0] = 2'b11; ps[1] = 2'b01; ps[2] = 2'b00;
    saw_low = 1'b0;
    for (int k = 0; k < 3; k++) begin
      store(ps[k], 8'hAA);
      for (int i = 0; i < 10; i++) begin
        if (tx !== 1'b1) saw_low = 1'b1;
        tick();
      end
    end
    checks++;
    if (saw_low || irq_empty !== 1'b1) begin
      failures++; $display("FAIL badsel_tx saw_low=%b irq=%b exp 0,1", saw_low, irq_empty);
    end
    read_status(2'b10, v);
    checks++;
    if (v !== 32'h0000_0010) begin
      failures++; $display("FAIL badsel_status got=%h exp=00000010", v);
    end
    read_status(2'b01, v);
    checks++;
    if (v !== 32'h0) begin
      failures++; $display("FAIL badsel_load01 got=%h exp=00000000", v);
    end
    read_status(2'b11, v);
    checks++;
    if (v !== 32'h0) begin
      failures++; $display("FAIL badsel_load11 got=%h exp=00000000", v);
    end
    pselect = 2'b10;
    #1;
    checks++;
    if (readdata !== 32'h0) begin
      failures++; $display("FAIL noload_readdata got=%h exp=00000000", readdata);
    end
    pselect = 2'b00;
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    int          c0;
    store(2'b10, 8'h01);
    c0 = cyc;
    store(2'b10, 8'h02);
    store(2'b10, 8'h03);
    store(2'b10, 8'h04);
    store(2'b10, 8'h05);
    store(2'b10, 8'hFF);
    read_status(2'b10, v);
    checks++;
    if (v !== 32'h0000_00E4) begin
      failures++; $display("FAIL ovf_set got=%h exp=000000e4", v);
    end
    pselect = 2'b10;
    re      = 1'b1;
    tick();
    re      = 1'b0;
    pselect = 2'b00;
    read_status(2'b10, v);
    checks++;
    if (v !== 32'h0000_0064) begin
      failures++; $display("FAIL ovf_clear got=%h exp=00000064", v);
    end
    wait_idle();
    checks++;
    if (cyc - c0 !== 201) begin
      failures++; $display("FAIL ovf_drain_cycles got=%0d exp=201", cyc - c0);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0]  v;
    logic [199:0] obs;
    logic [199:0] exp;
    store(2'b10, 8'h11);
    store(2'b10, 8'h81);
    store(2'b10, 8'h3C);
    store(2'b10, 8'hE7);
    store(2'b10, 8'h02);
    for (int i = 0; i < 36; i++) tick();
    read_status(2'b10, v);
    checks++;
    if (v !== 32'h0000_0064) begin
      failures++; $display("FAIL fullpop_pre got=%h exp=00000064", v);
    end
    store(2'b10, 8'hC5);
    read_status(2'b10, v);
    checks++;
    if (v !== 32'h0000_0064) begin
      failures++; $display("FAIL fullpop_post got=%h exp=00000064", v);
    end
    capture(200, obs);
    exp = {expand(FC5), expand(F02), expand(FE7), expand(F3C), expand(F81)};
    checks++;
    if (obs !== exp) begin
      failures++; $display("FAIL fullpop_frames got=%h exp=%h", obs, exp);
    end
    checks++;
    if (irq_empty !== 1'b1) begin
      failures++; $display("FAIL fullpop_done irq=%b exp=1", irq_empty);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    logic        saw_low;
    store(2'b10, 8'h00);
    store(2'b10, 8'h12);
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || irq_empty !== 1'b1) begin
      failures++; $display("FAIL midreset_tx tx=%b irq=%b exp 1,1", tx, irq_empty);
    end
    read_status(2'b10, v);
    checks++;
    if (v !== 32'h0000_0010) begin
      failures++; $display("FAIL midreset_status got=%h exp=00000010", v);
    end
    tick();
    tick();
    reset_n = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    checks++;
    if (saw_low || irq_empty !== 1'b1) begin
      failures++; $display("FAIL midreset_lost saw_low=%b irq=%b exp 0,1", saw_low, irq_empty);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    pselect   = 2'b00;
    we        = 1'b0;
    re        = 1'b0;
    writedata = 32'h0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_single();
    test_back_to_back();
    test_wrong_select();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
